// File: rtl/mc_req_buf.sv
// mc_req_buf: in-order load/store request FIFO between the vector unit and the memory controller; MC_REQ_BUF_STATS_EN builds the issue counters
module mc_req_buf #(
  parameter int DEPTH = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_req_ld,
  input  logic                     in_req_st,
  input  logic [47:0]              in_req_vadr,
  input  logic [63:0]              in_req_wrd_rdctl,
  output logic                     in_rd_rq_stall,
  output logic                     in_wr_rq_stall,
  output logic                     mc_req_ld,
  output logic                     mc_req_st,
  output logic [47:0]              mc_req_vadr,
  output logic [63:0]              mc_req_wrd_rdctl,
  input  logic                     mc_rd_rq_stall,
  input  logic                     mc_wr_rq_stall,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     idle,
  output logic                     err_ovf,
  output logic                     err_both,
  output logic [31:0]              ld_issued,
  output logic [31:0]              st_issued
);
  localparam int AW = $clog2(DEPTH);
  logic [112:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic r_rd_stall, r_wr_stall;
  logic [112:0] head;
  logic full, push_req, pop, push;
  logic [AW:0] cnt_nxt;
  assign head     = mem[rd_ptr];
  assign full     = q_cnt == (AW+1)'(DEPTH);
  assign push_req = in_req_ld ^ in_req_st;
  assign pop      = (q_cnt != '0) && !(head[112] ? r_wr_stall : r_rd_stall);
  assign push     = push_req && (!full || pop);
  assign cnt_nxt  = q_cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign idle     = (q_cnt == '0) && !mc_req_ld && !mc_req_st;
  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_req_st, in_req_vadr, in_req_wrd_rdctl};
  // Pointers, occupancy, registered stalls, MC request register and sticky errors.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      q_cnt            <= '0;
      r_rd_stall       <= 1'b0;
      r_wr_stall       <= 1'b0;
      in_rd_rq_stall   <= 1'b0;
      in_wr_rq_stall   <= 1'b0;
      mc_req_ld        <= 1'b0;
      mc_req_st        <= 1'b0;
      mc_req_vadr      <= '0;
      mc_req_wrd_rdctl <= '0;
      err_ovf          <= 1'b0;
      err_both         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      q_cnt          <= cnt_nxt;
      r_rd_stall     <= mc_rd_rq_stall;
      r_wr_stall     <= mc_wr_rq_stall;
      in_rd_rq_stall <= cnt_nxt >= (AW+1)'(AFULL_LVL);
      in_wr_rq_stall <= cnt_nxt >= (AW+1)'(AFULL_LVL);
      mc_req_ld      <= pop && !head[112];
      mc_req_st      <= pop && head[112];
      if (pop) begin
        mc_req_vadr      <= head[111:64];
        mc_req_wrd_rdctl <= head[63:0];
      end
      if (push_req && full && !pop) err_ovf <= 1'b1;
      if (in_req_ld && in_req_st) err_both <= 1'b1;
    end
`ifdef MC_REQ_BUF_STATS_EN
  // Per-type issue counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ld_issued <= '0;
      st_issued <= '0;
    end else begin
      if (pop && !head[112]) ld_issued <= ld_issued + 32'd1;
      if (pop && head[112]) st_issued <= st_issued + 32'd1;
    end
`else
  assign ld_issued = '0;
  assign st_issued = '0;
`endif
endmodule

// File: tb/tb_mc_req_buf.sv
// tb_mc_req_buf: randomized and directed checks of mc_req_buf against a queue-based reference model
module tb_mc_req_buf;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
`ifdef MC_REQ_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic in_req_ld = 1'b0, in_req_st = 1'b0;
  logic [47:0] in_req_vadr = '0;
  logic [63:0] in_req_wrd_rdctl = '0;
  logic in_rd_rq_stall, in_wr_rq_stall, mc_req_ld, mc_req_st;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic mc_rd_rq_stall = 1'b0, mc_wr_rq_stall = 1'b0;
  logic [$clog2(DEPTH):0] q_cnt;
  logic idle, err_ovf, err_both;
  logic [31:0] ld_issued, st_issued;
  int n_cmp = 0, n_fail = 0;

  mc_req_buf #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .reset(reset),
    .in_req_ld(in_req_ld), .in_req_st(in_req_st),
    .in_req_vadr(in_req_vadr), .in_req_wrd_rdctl(in_req_wrd_rdctl),
    .in_rd_rq_stall(in_rd_rq_stall), .in_wr_rq_stall(in_wr_rq_stall),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
    .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .q_cnt(q_cnt), .idle(idle), .err_ovf(err_ovf), .err_both(err_both),
    .ld_issued(ld_issued), .st_issued(st_issued)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic [47:0] va;
    logic [63:0] wd;
  } ent_t;
  ent_t mq[$];
  logic m_rs, m_ws, e_ld, e_st, e_ovf, e_both;
  logic [47:0] e_va;
  logic [63:0] e_wd;
  logic [31:0] n_ld, n_st;
  int issued;

  task automatic model_reset();
    mq.delete();
    m_rs = 0; m_ws = 0; e_ld = 0; e_st = 0; e_ovf = 0; e_both = 0;
    e_va = '0; e_wd = '0; n_ld = '0; n_st = '0;
  endtask

  task automatic step(input logic ld, input logic st, input logic [47:0] va,
                      input logic [63:0] wd, input logic rs, input logic ws);
    ent_t e;
    bit was_full, p;
    in_req_ld = ld; in_req_st = st; in_req_vadr = va; in_req_wrd_rdctl = wd;
    mc_rd_rq_stall = rs; mc_wr_rq_stall = ws;
    @(posedge clk);
    was_full = mq.size() == DEPTH;
    p = mq.size() > 0 && !(mq[0].st ? m_ws : m_rs);
    e_ld = 0; e_st = 0;
    if (p) begin
      e = mq.pop_front();
      e_ld = !e.st; e_st = e.st; e_va = e.va; e_wd = e.wd;
      if (e.st) n_st = n_st + 1; else n_ld = n_ld + 1;
    end
    if (ld && st) e_both = 1;
    else if (ld || st) begin
      if (!was_full || p) begin
        e.st = st; e.va = va; e.wd = wd;
        mq.push_back(e);
      end else e_ovf = 1;
    end
    m_rs = rs; m_ws = ws;
    @(negedge clk);
    if (mc_req_ld | mc_req_st) issued++;
    n_cmp++; if (mc_req_ld !== e_ld) begin n_fail++; $display("FAIL mc_req_ld: got %0b want %0b", mc_req_ld, e_ld); end
    n_cmp++; if (mc_req_st !== e_st) begin n_fail++; $display("FAIL mc_req_st: got %0b want %0b", mc_req_st, e_st); end
    n_cmp++; if (mc_req_vadr !== e_va) begin n_fail++; $display("FAIL mc_req_vadr: got %0h want %0h", mc_req_vadr, e_va); end
    n_cmp++; if (mc_req_wrd_rdctl !== e_wd) begin n_fail++; $display("FAIL mc_req_wrd_rdctl: got %0h want %0h", mc_req_wrd_rdctl, e_wd); end
    n_cmp++; if (int'(q_cnt) !== mq.size()) begin n_fail++; $display("FAIL q_cnt: got %0d want %0d", q_cnt, mq.size()); end
    n_cmp++; if (in_rd_rq_stall !== (mq.size() >= AFULL)) begin n_fail++; $display("FAIL in_rd_rq_stall: got %0b want %0b", in_rd_rq_stall, mq.size() >= AFULL); end
    n_cmp++; if (in_wr_rq_stall !== (mq.size() >= AFULL)) begin n_fail++; $display("FAIL in_wr_rq_stall: got %0b want %0b", in_wr_rq_stall, mq.size() >= AFULL); end
    n_cmp++; if (idle !== (mq.size() == 0 && !e_ld && !e_st)) begin n_fail++; $display("FAIL idle: got %0b want %0b", idle, mq.size() == 0 && !e_ld && !e_st); end
    n_cmp++; if (err_ovf !== e_ovf) begin n_fail++; $display("FAIL err_ovf: got %0b want %0b", err_ovf, e_ovf); end
    n_cmp++; if (err_both !== e_both) begin n_fail++; $display("FAIL err_both: got %0b want %0b", err_both, e_both); end
    n_cmp++; if (ld_issued !== (STATS ? n_ld : 32'd0)) begin n_fail++; $display("FAIL ld_issued: got %0d want %0d", ld_issued, STATS ? n_ld : 32'd0); end
    n_cmp++; if (st_issued !== (STATS ? n_st : 32'd0)) begin n_fail++; $display("FAIL st_issued: got %0d want %0d", st_issued, STATS ? n_st : 32'd0); end
  endtask

  task automatic idle_step(input logic rs, input logic ws);
    step(1'b0, 1'b0, '0, '0, rs, ws);
  endtask

  task automatic do_reset();
    in_req_ld = 0; in_req_st = 0; mc_rd_rq_stall = 0; mc_wr_rq_stall = 0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({mc_req_ld, mc_req_st, in_rd_rq_stall, in_wr_rq_stall, err_ovf, err_both} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %06b want 000000", {mc_req_ld, mc_req_st, in_rd_rq_stall, in_wr_rq_stall, err_ovf, err_both}); end
    n_cmp++; if (q_cnt !== '0) begin n_fail++; $display("FAIL reset_q_cnt: got %0d want 0", q_cnt); end
    n_cmp++; if ({mc_req_vadr, mc_req_wrd_rdctl} !== 112'b0) begin n_fail++; $display("FAIL reset_payload: got %0h want 0", {mc_req_vadr, mc_req_wrd_rdctl}); end
    n_cmp++; if ({ld_issued, st_issued} !== 64'b0) begin n_fail++; $display("FAIL reset_counters: got %0h want 0", {ld_issued, st_issued}); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", idle); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_load();
    step(1'b1, 1'b0, 48'h1000, 64'h10005, 1'b0, 1'b0);
    idle_step(1'b0, 1'b0);
    n_cmp++; if (mc_req_ld !== 1'b1 || mc_req_vadr !== 48'h1000 || mc_req_wrd_rdctl !== 64'h10005) begin n_fail++; $display("FAIL single_load: got ld=%0b va=%0h wd=%0h want ld=1 va=1000 wd=10005", mc_req_ld, mc_req_vadr, mc_req_wrd_rdctl); end
    idle_step(1'b0, 1'b0);
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_load_idle: got %0b want 1", idle); end
  endtask

  task automatic test_stall_order();
    step(1'b1, 1'b0, 48'h2000, 64'h1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 48'h2008, 64'hAA, 1'b1, 1'b0);
    issued = 0;
    for (int i = 0; i < 4; i++) idle_step(1'b1, 1'b0);
    n_cmp++; if (issued !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d issued want 0", issued); end
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b0);
    n_cmp++; if (mc_req_ld !== 1'b1 || mc_req_vadr !== 48'h2000) begin n_fail++; $display("FAIL stall_release_ld: got ld=%0b va=%0h want ld=1 va=2000", mc_req_ld, mc_req_vadr); end
    idle_step(1'b0, 1'b0);
    n_cmp++; if (mc_req_st !== 1'b1 || mc_req_wrd_rdctl !== 64'hAA) begin n_fail++; $display("FAIL stall_release_st: got st=%0b wd=%0h want st=1 wd=aa", mc_req_st, mc_req_wrd_rdctl); end
    idle_step(1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 48'(i), 64'(i * 3), 1'b1, 1'b1);
    n_cmp++; if (in_rd_rq_stall !== 1'b1 || in_wr_rq_stall !== 1'b1) begin n_fail++; $display("FAIL afull_stall: got %0b%0b want 11", in_rd_rq_stall, in_wr_rq_stall); end
    for (int i = 12; i < 16; i++) step(1'b0, 1'b1, 48'(i), 64'(i * 3), 1'b1, 1'b1);
    n_cmp++; if (q_cnt !== 5'd16 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_err: got q=%0d ovf=%0b want q=16 ovf=0", q_cnt, err_ovf); end
    step(1'b1, 1'b0, 48'hDEAD, 64'hBEEF, 1'b1, 1'b1);
    n_cmp++; if (q_cnt !== 5'd16 || err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: got q=%0d ovf=%0b want q=16 ovf=1", q_cnt, err_ovf); end
    for (int i = 0; i < 18; i++) idle_step(1'b0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) step(i[0] == 1'b0, i[0] == 1'b1, 48'(100 + i), 64'(i), 1'b1, 1'b1);
    issued = 0;
    idle_step(1'b0, 1'b0);
    step(1'b1, 1'b0, 48'h7777, 64'h17, 1'b0, 1'b0);
    n_cmp++; if (q_cnt !== 5'd16 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL full_push_pop: got q=%0d ovf=%0b want q=16 ovf=0", q_cnt, err_ovf); end
    for (int i = 0; i < 17; i++) idle_step(1'b0, 1'b0);
    n_cmp++; if (issued !== 17) begin n_fail++; $display("FAIL full_drain: got %0d issued want 17", issued); end
  endtask

  task automatic test_both_and_stats();
    do_reset();
    step(1'b1, 1'b1, 48'h55, 64'h66, 1'b0, 1'b0);
    n_cmp++; if (err_both !== 1'b1 || q_cnt !== '0) begin n_fail++; $display("FAIL both: got both=%0b q=%0d want both=1 q=0", err_both, q_cnt); end
    for (int i = 0; i < 8; i++) step(i < 5, i >= 5, 48'(i), 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step(1'b0, 1'b0);
    n_cmp++; if (ld_issued !== (STATS ? 32'd5 : 32'd0) || st_issued !== (STATS ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stats: got ld=%0d st=%0d want ld=%0d st=%0d", ld_issued, st_issued, STATS ? 5 : 0, STATS ? 3 : 0); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 48'(i + 1), 64'(i), 1'b1, 1'b1);
    n_cmp++; if (q_cnt !== 5'd7) begin n_fail++; $display("FAIL pre_reset_q: got %0d want 7", q_cnt); end
    do_reset();
    issued = 0;
    for (int i = 0; i < 5; i++) idle_step(1'b0, 1'b0);
    n_cmp++; if (issued !== 0) begin n_fail++; $display("FAIL post_reset_issue: got %0d want 0", issued); end
  endtask

  task automatic test_random();
    logic ld, st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ld = $urandom_range(99) < 45;
      st = $urandom_range(99) < 45;
      if (ld && st && $urandom_range(15) != 0) st = 1'b0;
      step(ld, st, {$urandom, $urandom}[47:0], {$urandom, $urandom},
           $urandom_range(99) < 30, $urandom_range(99) < 30);
    end
    for (int i = 0; i < 20; i++) idle_step(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_load();
    test_stall_order();
    test_overflow();
    test_full_push_pop();
    test_both_and_stats();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
